// File: rtl/raster_sequencer_if.sv
// Triangle-stream and rasterizer-control bundle for raster_sequencer.
// The master modport is the sequencer; slave is the upstream source plus rasterizer.
interface raster_sequencer_if #(
  parameter int VERT_RESOLUTION  = 60,
  parameter int HORIZ_RESOLUTION = 80
);
  localparam int XW = $clog2(HORIZ_RESOLUTION);
  localparam int YW = $clog2(VERT_RESOLUTION);

  logic                 i_tri_valid;
  logic                 o_tri_ready;
  logic [3*(XW+YW)-1:0] i_tri_data;
  logic                 o_go;
  logic [XW-1:0]        o_p0_x;
  logic [XW-1:0]        o_p1_x;
  logic [XW-1:0]        o_p2_x;
  logic [YW-1:0]        o_p0_y;
  logic [YW-1:0]        o_p1_y;
  logic [YW-1:0]        o_p2_y;
  logic                 i_done;
  logic                 o_rast_srst_n;
  logic                 o_busy;
  logic [15:0]          o_tri_count;
  logic                 o_error;

  modport master (
    input  i_tri_valid, i_tri_data, i_done,
    output o_tri_ready, o_go, o_p0_x, o_p1_x, o_p2_x, o_p0_y, o_p1_y, o_p2_y,
    output o_rast_srst_n, o_busy, o_tri_count, o_error
  );

  modport slave (
    output i_tri_valid, i_tri_data, i_done,
    input  o_tri_ready, o_go, o_p0_x, o_p1_x, o_p2_x, o_p0_y, o_p1_y, o_p2_y,
    input  o_rast_srst_n, o_busy, o_tri_count, o_error
  );
endinterface

// File: rtl/raster_sequencer.sv
// Queues triangles and launches them one at a time into a rasterizer, counting
// completions on i_done rising edges and aborting runaway rasterizations on timeout.
module raster_sequencer #(
  parameter int VERT_RESOLUTION  = 60,
  parameter int HORIZ_RESOLUTION = 80,
  parameter int FIFO_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES   = 8192
) (
  input  logic               i_clk,
  input  logic               i_rst,
  raster_sequencer_if.master bus
);
  localparam int YW = $clog2(VERT_RESOLUTION);
  localparam int XW = $clog2(HORIZ_RESOLUTION);
  localparam int DW = 3 * (XW + YW);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RECOVER
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [DW-1:0] r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_tri;
  logic          r_go;
  logic          r_srst_n;
  logic          r_error;
  logic          r_done_q;
  logic [15:0]   r_tri_count;
  logic [TW-1:0] r_timer;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_done_rise;
  logic          w_timeout;
  logic          w_go_next;
  logic          w_srst_n_next;
  logic          w_complete;
  logic          w_abort;
  logic [TW-1:0] w_timer_next;

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = bus.i_tri_valid && !w_full;
  assign w_done_rise = bus.i_done && !r_done_q;
  assign w_timeout   = (r_timer == TW'(TIMEOUT_CYCLES - 1));

  // A completion edge is checked before the timeout so a finish on the last
  // allowed cycle still counts as a normal completion.
  always_comb begin
    w_state_next  = r_state;
    w_pop         = 1'b0;
    w_go_next     = 1'b0;
    w_srst_n_next = 1'b1;
    w_complete    = 1'b0;
    w_abort       = 1'b0;
    w_timer_next  = '0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_go_next    = 1'b1;
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_done_rise) begin
          w_complete   = 1'b1;
          w_state_next = ST_IDLE;
        end else if (w_timeout) begin
          w_abort       = 1'b1;
          w_srst_n_next = 1'b0;
          w_state_next  = ST_RECOVER;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      ST_RECOVER: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_tri       <= '0;
      r_go        <= 1'b0;
      r_srst_n    <= 1'b0;
      r_error     <= 1'b0;
      r_done_q    <= 1'b0;
      r_tri_count <= '0;
      r_timer     <= '0;
    end else begin
      r_done_q <= bus.i_done;
      r_go     <= w_go_next;
      r_srst_n <= w_srst_n_next;
      r_timer  <= w_timer_next;
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_tri    <= r_fifo[r_rd_ptr];
      end
      if (w_complete) begin
        r_tri_count <= r_tri_count + 16'd1;
      end
      if (w_abort) begin
        r_error <= 1'b1;
      end
    end
  end

  // Storage needs no reset; emptiness is tracked entirely by r_count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= bus.i_tri_data;
    end
  end

  assign bus.o_tri_ready   = !w_full;
  assign bus.o_go          = r_go;
  assign bus.o_p0_x        = r_tri[XW-1:0];
  assign bus.o_p0_y        = r_tri[XW+YW-1:XW];
  assign bus.o_p1_x        = r_tri[(XW+YW)+XW-1:(XW+YW)];
  assign bus.o_p1_y        = r_tri[2*(XW+YW)-1:(XW+YW)+XW];
  assign bus.o_p2_x        = r_tri[2*(XW+YW)+XW-1:2*(XW+YW)];
  assign bus.o_p2_y        = r_tri[3*(XW+YW)-1:2*(XW+YW)+XW];
  assign bus.o_rast_srst_n = r_srst_n;
  assign bus.o_busy        = (r_state != ST_IDLE) || !w_empty;
  assign bus.o_tri_count   = r_tri_count;
  assign bus.o_error       = r_error;
endmodule

// File: tb/tb_raster_sequencer.sv
// Bench for raster_sequencer: a default-size instance for queueing and completion
// behaviour, plus a small instance with a 16-cycle timeout for the abort path.
module tb_raster_sequencer;
  localparam int VRES = 60;
  localparam int HRES = 80;
  localparam int XW   = 7;
  localparam int YW   = 6;
  localparam int DW   = 3 * (XW + YW);
  localparam int TVRES = 2;
  localparam int THRES = 4;
  localparam int TXW   = 2;
  localparam int TYW   = 1;
  localparam int TDW   = 3 * (TXW + TYW);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_count = 0;
  int   t_exp_count = 0;

  always #5 clk = ~clk;

  raster_sequencer_if #(.VERT_RESOLUTION(VRES), .HORIZ_RESOLUTION(HRES)) m_if ();
  raster_sequencer_if #(.VERT_RESOLUTION(TVRES), .HORIZ_RESOLUTION(THRES)) t_if ();

  raster_sequencer #(
    .VERT_RESOLUTION(VRES), .HORIZ_RESOLUTION(HRES), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8192)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .bus(m_if)
  );

  raster_sequencer #(
    .VERT_RESOLUTION(TVRES), .HORIZ_RESOLUTION(THRES), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) u_dut_to (
    .i_clk(clk), .i_rst(rst), .bus(t_if)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pack_tri(input int x0, y0, x1, y1, x2, y2);
    return {YW'(y2), XW'(x2), YW'(y1), XW'(x1), YW'(y0), XW'(x0)};
  endfunction

  function automatic logic [DW-1:0] rand_tri();
    return pack_tri($urandom_range(HRES-1), $urandom_range(VRES-1), $urandom_range(HRES-1),
                    $urandom_range(VRES-1), $urandom_range(HRES-1), $urandom_range(VRES-1));
  endfunction

  function automatic logic [TDW-1:0] t_rand_tri();
    return {TYW'($urandom_range(TVRES-1)), TXW'($urandom_range(THRES-1)),
            TYW'($urandom_range(TVRES-1)), TXW'($urandom_range(THRES-1)),
            TYW'($urandom_range(TVRES-1)), TXW'($urandom_range(THRES-1))};
  endfunction

  function automatic logic [DW-1:0] got_m();
    return {m_if.o_p2_y, m_if.o_p2_x, m_if.o_p1_y, m_if.o_p1_x, m_if.o_p0_y, m_if.o_p0_x};
  endfunction

  function automatic logic [TDW-1:0] got_t();
    return {t_if.o_p2_y, t_if.o_p2_x, t_if.o_p1_y, t_if.o_p1_x, t_if.o_p0_y, t_if.o_p0_x};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    m_if.i_tri_valid = 1'b0; m_if.i_tri_data = '0; m_if.i_done = 1'b0;
    t_if.i_tri_valid = 1'b0; t_if.i_tri_data = '0; t_if.i_done = 1'b0;
    step(2);
    n_checks++; if (m_if.o_go !== 1'b0 || m_if.o_rast_srst_n !== 1'b0 || m_if.o_error !== 1'b0)
      $display("[TB] FAIL reset_ctrl: go=%0b srst_n=%0b err=%0b expected 0/0/0", m_if.o_go, m_if.o_rast_srst_n, m_if.o_error); else n_pass++;
    n_checks++; if (m_if.o_tri_count !== 16'd0 || got_m() !== '0)
      $display("[TB] FAIL reset_data: count=%0d tri=%0h expected 0/0", m_if.o_tri_count, got_m()); else n_pass++;
    n_checks++; if (m_if.o_busy !== 1'b0 || m_if.o_tri_ready !== 1'b1)
      $display("[TB] FAIL reset_flow: busy=%0b ready=%0b expected 0/1", m_if.o_busy, m_if.o_tri_ready); else n_pass++;
    rst = 1'b0;
    #2;
    n_checks++; if (m_if.o_rast_srst_n !== 1'b0)
      $display("[TB] FAIL srst_before_edge: got %0b expected 0", m_if.o_rast_srst_n); else n_pass++;
    step(1);
    n_checks++; if (m_if.o_rast_srst_n !== 1'b1 || t_if.o_rast_srst_n !== 1'b1 || m_if.o_go !== 1'b0)
      $display("[TB] FAIL srst_release: srst_n=%0b/%0b go=%0b expected 1/1/0", m_if.o_rast_srst_n, t_if.o_rast_srst_n, m_if.o_go); else n_pass++;
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = pack_tri(1, 2, 10, 20, 30, 5);
    m_if.i_tri_data = d; m_if.i_tri_valid = 1'b1;
    step(1);
    m_if.i_tri_valid = 1'b0;
    n_checks++; if (m_if.o_go !== 1'b0)
      $display("[TB] FAIL single_early_go: got %0b expected 0", m_if.o_go); else n_pass++;
    step(1);
    n_checks++; if (m_if.o_go !== 1'b1 || got_m() !== d)
      $display("[TB] FAIL single_launch: go=%0b tri=%0h expected 1/%0h", m_if.o_go, got_m(), d); else n_pass++;
    step(1);
    n_checks++; if (m_if.o_go !== 1'b0)
      $display("[TB] FAIL single_go_pulse: got %0b expected 0", m_if.o_go); else n_pass++;
    step(4797);
    n_checks++; if (got_m() !== d || m_if.o_busy !== 1'b1 || m_if.o_tri_count !== 16'd0)
      $display("[TB] FAIL single_hold: tri=%0h busy=%0b count=%0d expected %0h/1/0", got_m(), m_if.o_busy, m_if.o_tri_count, d); else n_pass++;
    m_if.i_done = 1'b1;
    step(1);
    exp_count++;
    n_checks++; if (m_if.o_tri_count !== 16'(exp_count) || m_if.o_busy !== 1'b0)
      $display("[TB] FAIL single_done: count=%0d busy=%0b expected %0d/0", m_if.o_tri_count, m_if.o_busy, exp_count); else n_pass++;
  endtask

  task automatic test_fill();
    logic [DW-1:0] t [6];
    int idx;
    foreach (t[i]) t[i] = rand_tri();
    m_if.i_tri_data = t[0]; m_if.i_tri_valid = 1'b1;
    step(1);
    m_if.i_tri_valid = 1'b0;
    step(1);
    n_checks++; if (m_if.o_go !== 1'b1 || got_m() !== t[0])
      $display("[TB] FAIL fill_launch0: go=%0b tri=%0h expected 1/%0h", m_if.o_go, got_m(), t[0]); else n_pass++;
    m_if.i_done = 1'b0;
    idx = 1;
    m_if.i_tri_valid = 1'b1; m_if.i_tri_data = t[1];
    repeat (10) begin
      if (m_if.o_tri_ready) idx++;
      step(1);
      if (idx <= 5) m_if.i_tri_data = t[idx];
    end
    n_checks++; if (idx - 1 != 4 || m_if.o_tri_ready !== 1'b0)
      $display("[TB] FAIL fill_accept: accepted=%0d ready=%0b expected 4/0", idx - 1, m_if.o_tri_ready); else n_pass++;
    m_if.i_done = 1'b1;
    step(1);
    exp_count++;
    n_checks++; if (m_if.o_tri_ready !== 1'b0 || m_if.o_go !== 1'b0 || m_if.o_tri_count !== 16'(exp_count))
      $display("[TB] FAIL fill_idle: ready=%0b go=%0b count=%0d expected 0/0/%0d", m_if.o_tri_ready, m_if.o_go, m_if.o_tri_count, exp_count); else n_pass++;
    step(1);
    n_checks++; if (m_if.o_go !== 1'b1 || got_m() !== t[1] || m_if.o_tri_ready !== 1'b1)
      $display("[TB] FAIL fill_pop: go=%0b tri=%0h ready=%0b expected 1/%0h/1", m_if.o_go, got_m(), m_if.o_tri_ready, t[1]); else n_pass++;
    m_if.i_done = 1'b0;
    step(1);
    m_if.i_tri_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      step($urandom_range(1, 8));
      m_if.i_done = 1'b1;
      step(1);
      exp_count++;
      n_checks++; if (m_if.o_go !== 1'b0 || m_if.o_tri_count !== 16'(exp_count))
        $display("[TB] FAIL b2b_idle_%0d: go=%0b count=%0d expected 0/%0d", k, m_if.o_go, m_if.o_tri_count, exp_count); else n_pass++;
      step(1);
      n_checks++; if (m_if.o_go !== 1'b1 || got_m() !== t[k])
        $display("[TB] FAIL b2b_launch_%0d: go=%0b tri=%0h expected 1/%0h", k, m_if.o_go, got_m(), t[k]); else n_pass++;
      m_if.i_done = 1'b0;
    end
    step(3);
    m_if.i_done = 1'b1;
    step(1);
    exp_count++;
    n_checks++; if (m_if.o_tri_count !== 16'(exp_count) || m_if.o_busy !== 1'b0)
      $display("[TB] FAIL fill_drain: count=%0d busy=%0b expected %0d/0", m_if.o_tri_count, m_if.o_busy, exp_count); else n_pass++;
  endtask

  task automatic test_sticky_done();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    a = rand_tri(); b = rand_tri();
    m_if.i_tri_valid = 1'b1; m_if.i_tri_data = a;
    step(1);
    m_if.i_tri_data = b;
    step(1);
    m_if.i_tri_valid = 1'b0;
    n_checks++; if (m_if.o_go !== 1'b1 || got_m() !== a)
      $display("[TB] FAIL sticky_launch_a: go=%0b tri=%0h expected 1/%0h", m_if.o_go, got_m(), a); else n_pass++;
    step(10);
    n_checks++; if (m_if.o_tri_count !== 16'(exp_count) || m_if.o_busy !== 1'b1)
      $display("[TB] FAIL sticky_level_a: count=%0d busy=%0b expected %0d/1", m_if.o_tri_count, m_if.o_busy, exp_count); else n_pass++;
    m_if.i_done = 1'b0;
    step(1);
    m_if.i_done = 1'b1;
    step(1);
    exp_count++;
    n_checks++; if (m_if.o_tri_count !== 16'(exp_count))
      $display("[TB] FAIL sticky_edge_a: count=%0d expected %0d", m_if.o_tri_count, exp_count); else n_pass++;
    step(1);
    n_checks++; if (m_if.o_go !== 1'b1 || got_m() !== b)
      $display("[TB] FAIL sticky_launch_b: go=%0b tri=%0h expected 1/%0h", m_if.o_go, got_m(), b); else n_pass++;
    step(10);
    n_checks++; if (m_if.o_tri_count !== 16'(exp_count) || m_if.o_busy !== 1'b1)
      $display("[TB] FAIL sticky_level_b: count=%0d busy=%0b expected %0d/1", m_if.o_tri_count, m_if.o_busy, exp_count); else n_pass++;
    m_if.i_done = 1'b0;
    step(1);
    m_if.i_done = 1'b1;
    step(1);
    exp_count++;
    n_checks++; if (m_if.o_tri_count !== 16'(exp_count) || m_if.o_busy !== 1'b0)
      $display("[TB] FAIL sticky_edge_b: count=%0d busy=%0b expected %0d/0", m_if.o_tri_count, m_if.o_busy, exp_count); else n_pass++;
  endtask

  // Reference: triangles leave in push order, one in flight at a time, and each
  // rising edge of i_done while one is in flight completes exactly one triangle.
  task automatic test_random();
    logic [DW-1:0] pend[$];
    int to_push = 24;
    int pushed = 0;
    int delay = 0;
    int cyc = 0;
    bit inflight = 0;
    m_if.i_done = 1'b0;
    while (cyc < 4000 && !(pushed == to_push && pend.size() == 0 && !inflight)) begin
      if (m_if.o_go === 1'b1) begin
        n_checks++;
        if (inflight || pend.size() == 0 || got_m() !== pend[0])
          $display("[TB] FAIL random_launch: tri=%0h inflight=%0b queued=%0d expected %0h", got_m(), inflight, pend.size(), (pend.size() != 0) ? pend[0] : '0);
        else n_pass++;
        if (pend.size() != 0) void'(pend.pop_front());
        inflight = 1;
        delay = $urandom_range(0, 12);
        m_if.i_done = 1'b0;
      end else if (inflight) begin
        if (delay == 0) begin
          m_if.i_done = 1'b1;
          inflight = 0;
          exp_count++;
        end else begin
          delay--;
        end
      end
      if (pushed < to_push && $urandom_range(0, 2) != 0) begin
        m_if.i_tri_valid = 1'b1;
        m_if.i_tri_data = rand_tri();
      end else begin
        m_if.i_tri_valid = 1'b0;
      end
      if (m_if.i_tri_valid && m_if.o_tri_ready) begin
        pend.push_back(m_if.i_tri_data);
        pushed++;
      end
      step(1);
      cyc++;
    end
    m_if.i_tri_valid = 1'b0;
    step(1);
    n_checks++; if (cyc >= 4000)
      $display("[TB] FAIL random_budget: cycles=%0d pushed=%0d queued=%0d expected completion within 4000", cyc, pushed, pend.size()); else n_pass++;
    n_checks++; if (m_if.o_tri_count !== 16'(exp_count) || m_if.o_busy !== 1'b0)
      $display("[TB] FAIL random_count: count=%0d busy=%0b expected %0d/0", m_if.o_tri_count, m_if.o_busy, exp_count); else n_pass++;
  endtask

  task automatic test_timeout_race();
    logic [TDW-1:0] a;
    a = t_rand_tri();
    t_if.i_tri_valid = 1'b1; t_if.i_tri_data = a;
    step(1);
    t_if.i_tri_valid = 1'b0;
    step(1);
    n_checks++; if (t_if.o_go !== 1'b1 || got_t() !== a)
      $display("[TB] FAIL race_launch: go=%0b tri=%0h expected 1/%0h", t_if.o_go, got_t(), a); else n_pass++;
    step(15);
    n_checks++; if (t_if.o_error !== 1'b0 || t_if.o_busy !== 1'b1)
      $display("[TB] FAIL race_pre: err=%0b busy=%0b expected 0/1", t_if.o_error, t_if.o_busy); else n_pass++;
    t_if.i_done = 1'b1;
    step(1);
    t_exp_count++;
    n_checks++; if (t_if.o_tri_count !== 16'(t_exp_count) || t_if.o_error !== 1'b0 || t_if.o_rast_srst_n !== 1'b1 || t_if.o_busy !== 1'b0)
      $display("[TB] FAIL race_result: count=%0d err=%0b srst_n=%0b busy=%0b expected %0d/0/1/0", t_if.o_tri_count, t_if.o_error, t_if.o_rast_srst_n, t_if.o_busy, t_exp_count); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [TDW-1:0] a;
    logic [TDW-1:0] b;
    a = t_rand_tri(); b = t_rand_tri();
    t_if.i_tri_valid = 1'b1; t_if.i_tri_data = a;
    step(1);
    t_if.i_tri_data = b;
    step(1);
    t_if.i_tri_valid = 1'b0;
    t_if.i_done = 1'b0;
    n_checks++; if (t_if.o_go !== 1'b1 || got_t() !== a)
      $display("[TB] FAIL timeout_launch: go=%0b tri=%0h expected 1/%0h", t_if.o_go, got_t(), a); else n_pass++;
    step(15);
    n_checks++; if (t_if.o_error !== 1'b0 || t_if.o_rast_srst_n !== 1'b1)
      $display("[TB] FAIL timeout_early: err=%0b srst_n=%0b expected 0/1", t_if.o_error, t_if.o_rast_srst_n); else n_pass++;
    step(1);
    n_checks++; if (t_if.o_error !== 1'b1 || t_if.o_rast_srst_n !== 1'b0 || t_if.o_tri_count !== 16'(t_exp_count))
      $display("[TB] FAIL timeout_abort: err=%0b srst_n=%0b count=%0d expected 1/0/%0d", t_if.o_error, t_if.o_rast_srst_n, t_if.o_tri_count, t_exp_count); else n_pass++;
    step(1);
    n_checks++; if (t_if.o_rast_srst_n !== 1'b1 || t_if.o_go !== 1'b0 || t_if.o_busy !== 1'b1)
      $display("[TB] FAIL timeout_recover: srst_n=%0b go=%0b busy=%0b expected 1/0/1", t_if.o_rast_srst_n, t_if.o_go, t_if.o_busy); else n_pass++;
    step(1);
    n_checks++; if (t_if.o_go !== 1'b1 || got_t() !== b || t_if.o_error !== 1'b1)
      $display("[TB] FAIL timeout_next: go=%0b tri=%0h err=%0b expected 1/%0h/1", t_if.o_go, got_t(), t_if.o_error, b); else n_pass++;
    step(2);
    t_if.i_done = 1'b1;
    step(1);
    t_exp_count++;
    n_checks++; if (t_if.o_tri_count !== 16'(t_exp_count) || t_if.o_error !== 1'b1)
      $display("[TB] FAIL timeout_sticky: count=%0d err=%0b expected %0d/1", t_if.o_tri_count, t_if.o_error, t_exp_count); else n_pass++;
  endtask

  task automatic test_reset_mid_busy();
    bit saw_go = 0;
    m_if.i_tri_valid = 1'b1;
    m_if.i_tri_data = rand_tri();
    step(1);
    m_if.i_tri_data = rand_tri();
    step(1);
    m_if.i_done = 1'b0;
    m_if.i_tri_data = rand_tri();
    step(1);
    m_if.i_tri_data = rand_tri();
    step(1);
    m_if.i_tri_valid = 1'b0;
    n_checks++; if (m_if.o_busy !== 1'b1 || m_if.o_tri_count !== 16'(exp_count) || got_m() === '0)
      $display("[TB] FAIL midbusy_setup: busy=%0b count=%0d tri=%0h expected 1/%0d/nonzero", m_if.o_busy, m_if.o_tri_count, got_m(), exp_count); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (m_if.o_go !== 1'b0 || m_if.o_tri_count !== 16'd0 || m_if.o_busy !== 1'b0 || got_m() !== '0)
      $display("[TB] FAIL midbusy_reset: go=%0b count=%0d busy=%0b tri=%0h expected 0/0/0/0", m_if.o_go, m_if.o_tri_count, m_if.o_busy, got_m()); else n_pass++;
    n_checks++; if (m_if.o_rast_srst_n !== 1'b0 || m_if.o_tri_ready !== 1'b1 || t_if.o_error !== 1'b0 || t_if.o_tri_count !== 16'd0)
      $display("[TB] FAIL midbusy_reset2: srst_n=%0b ready=%0b t_err=%0b t_count=%0d expected 0/1/0/0", m_if.o_rast_srst_n, m_if.o_tri_ready, t_if.o_error, t_if.o_tri_count); else n_pass++;
    step(1);
    rst = 1'b0;
    repeat (10) begin
      step(1);
      if (m_if.o_go !== 1'b0) saw_go = 1;
    end
    n_checks++; if (saw_go || m_if.o_tri_ready !== 1'b1 || m_if.o_busy !== 1'b0 || m_if.o_rast_srst_n !== 1'b1)
      $display("[TB] FAIL midbusy_after: saw_go=%0b ready=%0b busy=%0b srst_n=%0b expected 0/1/0/1", saw_go, m_if.o_tri_ready, m_if.o_busy, m_if.o_rast_srst_n); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_sticky_done();
    test_random();
    test_timeout_race();
    test_timeout();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
